// File: rtl/player_keys_pkg.sv
// Shared types, default key codes and helpers for the player direction-key front end.
package player_keys_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic {BOMB_IDLE, BOMB_HELD} bomb_state_t;

    // Bit 8 marks an E0-extended scan code.
    localparam logic [8:0] KEY_UP_DEF    = 9'h175;
    localparam logic [8:0] KEY_DOWN_DEF  = 9'h172;
    localparam logic [8:0] KEY_LEFT_DEF  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT_DEF = 9'h174;
    localparam logic [8:0] KEY_BOMB_DEF  = 9'h029;

    localparam int unsigned STACK_DEPTH = 4;

    // Returns {up, down, left, right}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] v;
        case (d)
            DIR_UP:    v = 4'b1000;
            DIR_DOWN:  v = 4'b0100;
            DIR_LEFT:  v = 4'b0010;
            DIR_RIGHT: v = 4'b0001;
            default:   v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dir_press_stack.sv
// Most-recent-first stack of held direction keys; entry 0 is the newest press.
module dir_press_stack
    import player_keys_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  dir_t       i_push_dir,
    input  logic       i_remove,
    input  dir_t       i_remove_dir,
    output dir_t       o_entry0,
    output logic [2:0] o_count
);

    dir_t       r_entry [STACK_DEPTH];
    logic [2:0] r_count;

    dir_t       w_entry [STACK_DEPTH];
    logic [2:0] w_count;
    logic       w_push_hit;
    logic       w_rm_hit;
    logic [1:0] w_rm_idx;

    // Look up both event directions among the valid entries.
    always_comb begin
        w_push_hit = 1'b0;
        w_rm_hit   = 1'b0;
        w_rm_idx   = 2'd0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (3'(i) < r_count && r_entry[i] == i_push_dir) begin
                w_push_hit = 1'b1;
            end
            if (3'(i) < r_count && r_entry[i] == i_remove_dir) begin
                w_rm_hit = 1'b1;
                w_rm_idx = 2'(i);
            end
        end
    end

    // Next stack: push new key on top, or close the gap left by a released key.
    always_comb begin
        w_entry = r_entry;
        w_count = r_count;
        if (i_push && !w_push_hit && r_count < 3'(STACK_DEPTH)) begin
            for (int i = STACK_DEPTH - 1; i > 0; i--) begin
                w_entry[i] = r_entry[i-1];
            end
            w_entry[0] = i_push_dir;
            w_count    = r_count + 3'd1;
        end else if (i_remove && w_rm_hit) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (i >= int'(w_rm_idx)) begin
                    w_entry[i] = r_entry[i+1];
                end
            end
            w_count = r_count - 3'd1;
        end
    end

    // Stack state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 3'd0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_entry[i] <= DIR_UP;
            end
        end else begin
            r_count <= w_count;
            r_entry <= w_entry;
        end
    end

    assign o_entry0 = r_entry[0];
    assign o_count  = r_count;

endmodule

// File: rtl/player_dir_keys.sv
// Turns keyboard make/break events into per-frame direction levels and a bomb pulse.
module player_dir_keys
    import player_keys_pkg::*;
#(
    parameter logic [8:0] KEY_UP    = KEY_UP_DEF,
    parameter logic [8:0] KEY_DOWN  = KEY_DOWN_DEF,
    parameter logic [8:0] KEY_LEFT  = KEY_LEFT_DEF,
    parameter logic [8:0] KEY_RIGHT = KEY_RIGHT_DEF,
    parameter logic [8:0] KEY_BOMB  = KEY_BOMB_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    input  logic       startOfFrame,
    output logic       up_direction_key,
    output logic       down_direction_key,
    output logic       left_direction_key,
    output logic       right_direction_key,
    output logic       bomb_key
);

    logic        w_event_ok;
    logic        w_is_dir;
    dir_t        w_dir;
    logic        w_push;
    logic        w_remove;
    logic        w_bomb_make;
    logic        w_bomb_brk;
    dir_t        w_entry0;
    logic [2:0]  w_count;

    logic [3:0]  r_dirs;
    bomb_state_t r_bomb_state;
    bomb_state_t w_bomb_state_next;
    logic        r_bomb_pend;
    logic        w_bomb_pend_next;
    logic        w_bomb_pulse;

    // Decode the current event; a simultaneous make and break is discarded.
    always_comb begin
        w_event_ok = !(make && brakee);
        w_is_dir   = 1'b1;
        w_dir      = DIR_UP;
        if (keyCode == KEY_UP) begin
            w_dir = DIR_UP;
        end else if (keyCode == KEY_DOWN) begin
            w_dir = DIR_DOWN;
        end else if (keyCode == KEY_LEFT) begin
            w_dir = DIR_LEFT;
        end else if (keyCode == KEY_RIGHT) begin
            w_dir = DIR_RIGHT;
        end else begin
            w_is_dir = 1'b0;
        end
        w_push      = w_event_ok && make && w_is_dir;
        w_remove    = w_event_ok && brakee && w_is_dir;
        w_bomb_make = w_event_ok && make && (keyCode == KEY_BOMB);
        w_bomb_brk  = w_event_ok && brakee && (keyCode == KEY_BOMB);
    end

    dir_press_stack u_stack (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_dir   (w_dir),
        .i_remove     (w_remove),
        .i_remove_dir (w_dir),
        .o_entry0     (w_entry0),
        .o_count      (w_count)
    );

    // Sample the pre-update stack top once per frame; hold in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirs <= 4'b0000;
        end else if (startOfFrame) begin
            r_dirs <= (w_count != 3'd0) ? dir_onehot(w_entry0) : 4'b0000;
        end
    end

    // Bomb FSM state and pending-pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bomb_state <= BOMB_IDLE;
            r_bomb_pend  <= 1'b0;
        end else begin
            r_bomb_state <= w_bomb_state_next;
            r_bomb_pend  <= w_bomb_pend_next;
        end
    end

    // Bomb FSM next state; a press in the frame-start cycle survives for the next frame.
    always_comb begin
        w_bomb_state_next = r_bomb_state;
        w_bomb_pend_next  = r_bomb_pend;
        w_bomb_pulse      = 1'b0;
        if (startOfFrame && r_bomb_pend) begin
            w_bomb_pulse     = 1'b1;
            w_bomb_pend_next = 1'b0;
        end
        case (r_bomb_state)
            BOMB_IDLE: begin
                if (w_bomb_make) begin
                    w_bomb_pend_next  = 1'b1;
                    w_bomb_state_next = BOMB_HELD;
                end
            end
            BOMB_HELD: begin
                if (w_bomb_brk) begin
                    w_bomb_state_next = BOMB_IDLE;
                end
            end
            default: w_bomb_state_next = BOMB_IDLE;
        endcase
    end

    assign up_direction_key    = r_dirs[3];
    assign down_direction_key  = r_dirs[2];
    assign left_direction_key  = r_dirs[1];
    assign right_direction_key = r_dirs[0];
    assign bomb_key            = w_bomb_pulse && !reset;

endmodule

// File: tb/tb_player_dir_keys.sv
// Directed and randomized check of player_dir_keys against a queue-based reference model.
module tb_player_dir_keys;

    logic       clk;
    logic       reset;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       startOfFrame;
    logic       up_direction_key;
    logic       down_direction_key;
    logic       left_direction_key;
    logic       right_direction_key;
    logic       bomb_key;

    int checks;
    int failures;

    // Reference model state: held directions newest first, outputs, bomb flags.
    int         stk[$];
    logic [3:0] m_dir;
    bit         m_pend;
    bit         m_held;

    logic [8:0] codes [7] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h199, 9'h075};

    player_dir_keys dut (
        .clk                 (clk),
        .reset               (reset),
        .keyCode             (keyCode),
        .make                (make),
        .brakee              (brakee),
        .startOfFrame        (startOfFrame),
        .up_direction_key    (up_direction_key),
        .down_direction_key  (down_direction_key),
        .left_direction_key  (left_direction_key),
        .right_direction_key (right_direction_key),
        .bomb_key            (bomb_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int code2dir(input logic [8:0] c);
        if (c == 9'h175) return 0;
        if (c == 9'h172) return 1;
        if (c == 9'h16B) return 2;
        if (c == 9'h174) return 3;
        return -1;
    endfunction

    // Compare every cycle at the falling edge, then advance the model with this cycle's inputs.
    always @(negedge clk) begin : cmp
        logic exp_bomb;
        int   d;
        int   idx;
        bit   pend_n;
        exp_bomb = !reset && startOfFrame && m_pend;
        checks++;
        if ({up_direction_key, down_direction_key, left_direction_key, right_direction_key}
                !== m_dir || bomb_key !== exp_bomb) begin
            failures++;
            $display("FAIL model_cmp t=%0t got dirs=%b bomb=%b expected dirs=%b bomb=%b", $time,
                     {up_direction_key, down_direction_key, left_direction_key,
                      right_direction_key}, bomb_key, m_dir, exp_bomb);
        end
        if (reset) begin
            stk.delete();
            m_dir  = 4'b0000;
            m_pend = 1'b0;
            m_held = 1'b0;
        end else begin
            if (startOfFrame) begin
                m_dir = (stk.size() > 0) ? (4'b1000 >> stk[0]) : 4'b0000;
            end
            pend_n = startOfFrame ? 1'b0 : m_pend;
            if (!(make && brakee)) begin
                d = code2dir(keyCode);
                if (d >= 0) begin
                    idx = -1;
                    foreach (stk[k]) if (stk[k] == d) idx = k;
                    if (make && idx < 0) stk.push_front(d);
                    if (brakee && idx >= 0) stk.delete(idx);
                end
                if (keyCode == 9'h029) begin
                    if (make && !m_held) begin
                        pend_n = 1'b1;
                        m_held = 1'b1;
                    end
                    if (brakee) m_held = 1'b0;
                end
            end
            m_pend = pend_n;
        end
    end

    task automatic step(input logic r, input logic [8:0] c, input logic mk, input logic br,
                        input logic sof);
        @(posedge clk);
        #1;
        reset        = r;
        keyCode      = c;
        make         = mk;
        brakee       = br;
        startOfFrame = sof;
    endtask

    task automatic idle();
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic press(input logic [8:0] c);
        step(1'b0, c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic release_key(input logic [8:0] c);
        step(1'b0, c, 1'b0, 1'b1, 1'b0);
    endtask

    // Hand-computed expectation on {up,down,left,right,bomb} in the current cycle.
    task automatic lit(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        #5;
        act = {up_direction_key, down_direction_key, left_direction_key, right_direction_key,
               bomb_key};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", nm, act, exp);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        m_dir        = 4'b0000;
        m_pend       = 1'b0;
        m_held       = 1'b0;
        reset        = 1'b1;
        keyCode      = 9'h000;
        make         = 1'b0;
        brakee       = 1'b0;
        startOfFrame = 1'b0;
        idle();

        // Reset in the middle of a held key and a pending bomb.
        press(9'h175);
        press(9'h029);
        frame();
        lit("pre_reset_up", 5'b10000);
        press(9'h029);
        step(1'b1, 9'h174, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h029, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h000, 1'b0, 1'b0, 1'b1);
        idle();
        lit("reset_outputs", 5'b00000);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        lit("reset_no_bomb", 5'b00000);
        idle();
        lit("reset_empty", 5'b00000);
        release_key(9'h175);
        release_key(9'h029);

        // Single key press and release.
        press(9'h175);
        frame();
        lit("single_up", 5'b10000);
        release_key(9'h175);
        frame();
        lit("single_up_rel", 5'b00000);

        // Last pressed wins.
        press(9'h16B);
        press(9'h175);
        frame();
        lit("prio_up", 5'b10000);
        release_key(9'h175);
        frame();
        lit("prio_left", 5'b00100);
        release_key(9'h16B);
        frame();
        lit("prio_none", 5'b00000);

        // Typematic repeats do not reorder; unknown break ignored.
        press(9'h172);
        for (int i = 0; i < 20; i++) press(9'h174);
        frame();
        lit("typ_right", 5'b00010);
        press(9'h172);
        frame();
        lit("typ_no_reorder", 5'b00010);
        release_key(9'h199);
        frame();
        lit("typ_unknown_brk", 5'b00010);
        release_key(9'h174);
        frame();
        lit("typ_down", 5'b01000);
        release_key(9'h172);
        frame();
        lit("typ_none", 5'b00000);

        // Three bomb taps in one frame give one pulse; held repeats give none.
        for (int i = 0; i < 3; i++) begin
            press(9'h029);
            release_key(9'h029);
        end
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        lit("bomb_pulse", 5'b00001);
        idle();
        lit("bomb_single", 5'b00000);
        press(9'h029);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        lit("bomb_hold_pulse", 5'b00001);
        for (int i = 0; i < 3; i++) press(9'h029);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        lit("bomb_repeat_none", 5'b00000);
        release_key(9'h029);

        // Fill the stack, then release in reverse order.
        press(9'h175);
        press(9'h172);
        press(9'h16B);
        press(9'h174);
        press(9'h175);
        frame();
        lit("full_right", 5'b00010);
        release_key(9'h174);
        frame();
        lit("full_left", 5'b00100);
        release_key(9'h16B);
        frame();
        lit("full_down", 5'b01000);
        release_key(9'h172);
        frame();
        lit("full_up", 5'b10000);
        release_key(9'h175);
        frame();
        lit("full_empty", 5'b00000);
        release_key(9'h175);
        frame();
        lit("underflow", 5'b00000);

        // Simultaneous make and break is ignored.
        step(1'b0, 9'h175, 1'b1, 1'b1, 1'b0);
        frame();
        lit("mk_brk_empty", 5'b00000);
        press(9'h16B);
        step(1'b0, 9'h175, 1'b1, 1'b1, 1'b0);
        step(1'b0, 9'h16B, 1'b1, 1'b1, 1'b0);
        frame();
        lit("mk_brk_held", 5'b00100);
        release_key(9'h16B);
        frame();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0), codes[$urandom_range(0, 6)],
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 7) == 0));
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
